addsub_sequencer: RTL and testbench

Operand-entry and execution controller for the 8-bit AddSub datapath on the board-level calculator. It debounces the three push buttons and walks the user through operand A entry, operand B entry and execution. It captures the datapath result and flags into stable registers and selects what the seven-segment display path shows. It sits between the raw board I/O (sw, btn) and the AddSub / Bin2Bcd / digit_display chain, and supports chained operations (result becomes next operand A).

---
 rtl/addsub_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_addsub_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// Operand-entry and execution controller for the 8-bit AddSub datapath.
// Conditions the three push buttons, sequences operand A/B entry and
// execution, and captures the datapath result and flags into stable registers.
module addsub_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic [2:0] btn,
  input  logic [7:0] S_in,
  input  logic       ovf_in,
  input  logic       neg_in,
  output logic [7:0] op1,
  output logic [7:0] op2,
  output logic       sub,
  output logic [7:0] result,
  output logic       overflow,
  output logic       neg,
  output logic [1:0] disp_sel,
  output logic [1:0] state_led,
  output logic       done
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    StEnterA = 2'd0,
    StEnterB = 2'd1,
    StExec   = 2'd2,
    StShow   = 2'd3
  } state_e;

  // Button conditioning state: [0] enter, [1] toggle, [2] clear
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      level_q, level_d;
  logic [2:0]      prev_q;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [2:0]      pulse;

  logic pulse_enter, pulse_toggle, pulse_clear;

  // Synchronizers, debouncer levels/counters and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Debounce: count while synced level disagrees, flip once count reaches the limit
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // One pulse per accepted 0->1 transition
  assign pulse        = level_q & ~prev_q;
  assign pulse_enter  = pulse[0];
  assign pulse_toggle = pulse[1];
  assign pulse_clear  = pulse[2];

  state_e     state_q, state_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic       sub_q, sub_d;
  logic [7:0] result_q, result_d;
  logic       ovf_q, ovf_d;
  logic       neg_q, neg_d;
  logic       done_q, done_d;
  logic       show_q, show_d;

  // Sequencer state and captured datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StEnterA;
      op1_q    <= '0;
      op2_q    <= '0;
      sub_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      show_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      sub_q    <= sub_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      show_q   <= show_d;
    end
  end

  // Next-state and register updates; clear outranks enter/toggle
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    sub_d    = sub_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    show_d   = (state_q == StShow);

    if (state_q == StExec) begin
      result_d = S_in;
      ovf_d    = ovf_in;
      neg_d    = neg_in;
      done_d   = 1'b1;
      // A clear landing during capture still lets capture finish first
      state_d  = pulse_clear ? StEnterA : StShow;
    end else if (pulse_clear) begin
      op1_d    = '0;
      op2_d    = '0;
      result_d = '0;
      ovf_d    = 1'b0;
      neg_d    = 1'b0;
      state_d  = StEnterA;
    end else begin
      if (pulse_toggle) begin
        sub_d = ~sub_q;
      end
      if (pulse_enter) begin
        unique case (state_q)
          StEnterA: begin
            op1_d   = sw;
            state_d = StEnterB;
          end
          StEnterB: begin
            op2_d   = sw;
            state_d = StExec;
          end
          StShow: begin
            op1_d   = result_q;
            state_d = StEnterB;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  assign op1       = op1_q;
  assign op2       = op2_q;
  assign sub       = sub_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign neg       = neg_q;
  assign done      = done_q;
  assign disp_sel  = {1'b0, show_q};
  assign state_led = state_q;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer with a behavioural AddSub model.
module tb_addsub_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic [2:0] btn;
  logic [7:0] S_in;
  logic       ovf_in;
  logic       neg_in;
  logic [7:0] op1, op2, result;
  logic       sub, overflow, neg, done;
  logic [1:0] disp_sel, state_led;

  int n_cmp;
  int n_bad;
  int done_cnt;
  int exec_cnt;
  int lat;

  addsub_sequencer #(
    .DEBOUNCE_CYCLES(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn       (btn),
    .S_in      (S_in),
    .ovf_in    (ovf_in),
    .neg_in    (neg_in),
    .op1       (op1),
    .op2       (op2),
    .sub       (sub),
    .result    (result),
    .overflow  (overflow),
    .neg       (neg),
    .disp_sel  (disp_sel),
    .state_led (state_led),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational AddSub model driving the datapath inputs
  always_comb begin
    S_in   = sub ? (op1 - op2) : (op1 + op2);
    ovf_in = sub ? ((op1[7] != op2[7]) && (S_in[7] != op1[7]))
                 : ((op1[7] == op2[7]) && (S_in[7] != op1[7]));
    neg_in = S_in[7];
  end

  // Count done pulses and EXEC cycles mid-cycle
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (state_led == 2'd2) exec_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold the buttons long enough to debounce press and release
  task automatic press(input logic [2:0] b);
    btn = b;
    repeat (12) @(posedge clk);
    #1 btn = 3'b000;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic enter_val(input logic [7:0] v);
    sw = v;
    press(3'b001);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; done_cnt = 0; exec_cnt = 0; lat = 0;
    rst = 1'b1; sw = '0; btn = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_op1", op1, 0);
    check("rst_op2", op2, 0);
    check("rst_result", result, 0);
    check("rst_sub", sub, 0);
    check("rst_flags", {overflow, neg, done}, 0);
    check("rst_disp", disp_sel, 0);
    check("rst_state", state_led, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Add with latency measurement on the first enter
    sw = 8'd25;
    btn = 3'b001;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (state_led != 2'd0) begin
        lat = i;
        break;
      end
    end
    check("enter_latency", lat, 8);
    btn = 3'b000;
    repeat (12) @(posedge clk);
    #1;
    check("add_state_b", state_led, 1);
    check("add_op1", op1, 25);
    check("add_disp_b", disp_sel, 0);
    enter_val(8'd17);
    check("add_state_show", state_led, 3);
    check("add_op2", op2, 17);
    check("add_result", result, 8'h2A);
    check("add_flags", {overflow, neg}, 2'b00);
    check("add_disp_show", disp_sel, 1);
    check("add_done_cnt", done_cnt, 1);
    check("add_exec_cnt", exec_cnt, 1);

    // Chain: toggle in SHOW must not recompute
    press(3'b010);
    check("chain_sub", sub, 1);
    check("chain_hold", result, 8'h2A);
    press(3'b010);
    check("chain_sub0", sub, 0);
    enter_val(8'd8);
    check("chain_state_b", state_led, 1);
    check("chain_op1", op1, 42);
    enter_val(8'd8);
    check("chain_op2", op2, 8);
    check("chain_result", result, 50);
    check("chain_done_cnt", done_cnt, 2);

    // Clear preserves sub, zeroes everything else
    press(3'b010);
    press(3'b100);
    check("clr_state", state_led, 0);
    check("clr_regs", {op1, op2, result}, 0);
    check("clr_sub", sub, 1);

    // Subtract: 10 - 20
    enter_val(8'd10);
    enter_val(8'd20);
    check("sub_result", result, 8'hF6);
    check("sub_flags", {overflow, neg}, 2'b01);

    // Overflow: 100 + 100
    press(3'b100);
    press(3'b010);
    check("ovf_sub", sub, 0);
    enter_val(8'd100);
    enter_val(8'd100);
    check("ovf_result", result, 8'hC8);
    check("ovf_flags", {overflow, neg}, 2'b11);

    // Glitch of 3 cycles on enter
    press(3'b100);
    btn = 3'b001;
    repeat (3) @(posedge clk);
    #1 btn = 3'b000;
    repeat (15) @(posedge clk);
    #1;
    check("glitch_state", state_led, 0);
    check("glitch_op1", op1, 0);

    // Clear and enter together in ENTER_B
    enter_val(8'd5);
    check("pri_pre_state", state_led, 1);
    press(3'b101);
    check("pri_state", state_led, 0);
    check("pri_ops", {op1, op2}, 0);

    // Asynchronous reset while in EXEC
    enter_val(8'd3);
    sw = 8'd4;
    btn = 3'b001;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (state_led == 2'd2) begin
        lat = i;
        break;
      end
    end
    check("exec_reached", (lat != 0), 1);
    lat = done_cnt;
    #1 rst = 1'b1;
    #1;
    check("arst_state", state_led, 0);
    check("arst_ops", {op1, op2, result}, 0);
    check("arst_flags", {sub, overflow, neg, done, disp_sel}, 0);
    btn = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_done", done_cnt, lat);
    check("arst_idle", state_led, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
